// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the MM:SS countdown timer.
// Holds the FSM state encoding, the BCD digit width and the per-digit
// limits, plus the preset clamping helper used by the top level.
package countdown_timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX_ONES = 4'd9;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX_TENS = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Out-of-range BCD digits saturate at the digit's maximum.
  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] d,
    input logic [DIGIT_W-1:0] max
  );
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit of the countdown borrow chain.
// Ports:
//   clock, reset   - rising-edge clock, async active-high reset
//   load           - synchronous load of load_value (wins over decrement)
//   load_value     - value to load
//   dec_en         - decrement enable for the whole chain this cycle
//   borrow_in      - borrow from the less significant digit
//   digit          - current digit value
//   borrow_out     - digit is 0 while a borrow arrives (propagates upward)
module bcd_down_digit
  import countdown_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX_ONES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_value,
  input  logic               dec_en,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] r_digit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_digit <= '0;
    end else if (load) begin
      r_digit <= load_value;
    end else if (dec_en && borrow_in) begin
      r_digit <= (r_digit == '0) ? MAX : (r_digit - DIGIT_W'(1));
    end
  end

  assign digit      = r_digit;
  assign borrow_out = borrow_in && (r_digit == '0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with done pulse and latched, auto-silencing alarm.
// Ports:
//   clock, reset            - rising-edge clock, async active-high reset
//   tick                    - 1 Hz single-cycle enable
//   load, start_stop, clear - single-cycle control pulses
//                             (priority clear > load > start_stop > tick)
//   preset_*                - BCD preset digits, clamped at load
//   min_tens..sec_ones      - current count, BCD
//   running                 - state is RUN
//   done                    - one-cycle pulse when RUN reaches 00:00
//   alarm                   - state is EXPIRED
// Parameter ALARM_TICKS: ticks spent in EXPIRED before auto-return to IDLE
// (0 keeps the alarm until a control pulse).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               load,
  input  logic               start_stop,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] preset_min_tens,
  input  logic [DIGIT_W-1:0] preset_min_ones,
  input  logic [DIGIT_W-1:0] preset_sec_tens,
  input  logic [DIGIT_W-1:0] preset_sec_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               done,
  output logic               alarm
);

  localparam int unsigned AW = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;

  state_t          r_state, w_state_nxt;
  logic            r_done, w_done_nxt;
  logic [AW-1:0]   r_alarm_cnt, w_alarm_cnt_nxt, w_alarm_cnt_inc;

  logic            w_digit_load;
  logic            w_use_preset;
  logic            w_dec;
  logic            w_zero;
  logic            w_one;

  logic [DIGIT_W-1:0] w_ld_mt, w_ld_mo, w_ld_st, w_ld_so;
  logic               w_borrow_so, w_borrow_st, w_borrow_mo, w_borrow_mt;

  // A borrow leaving the top digit with sec_ones borrow_in tied high means
  // every digit is zero, so the chain doubles as the 00:00 detector.
  assign w_zero = w_borrow_mt;
  assign w_one  = (min_tens == '0) && (min_ones == '0) &&
                  (sec_tens == '0) && (sec_ones == DIGIT_W'(1));

  assign w_alarm_cnt_inc = r_alarm_cnt + AW'(1);

  // Clear and load share the digit load path; only the source differs.
  assign w_ld_mt = w_use_preset ? clamp_digit(preset_min_tens, DIGIT_MAX_TENS) : '0;
  assign w_ld_mo = w_use_preset ? clamp_digit(preset_min_ones, DIGIT_MAX_ONES) : '0;
  assign w_ld_st = w_use_preset ? clamp_digit(preset_sec_tens, DIGIT_MAX_TENS) : '0;
  assign w_ld_so = w_use_preset ? clamp_digit(preset_sec_ones, DIGIT_MAX_ONES) : '0;

  // The if/else ordering in each state implements the input priority, so a
  // lower-priority pulse coinciding with a higher one is simply dropped.
  always_comb begin
    w_state_nxt     = r_state;
    w_done_nxt      = 1'b0;
    w_alarm_cnt_nxt = r_alarm_cnt;
    w_digit_load    = 1'b0;
    w_use_preset    = 1'b0;
    w_dec           = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_digit_load = 1'b1;
        end else if (load) begin
          w_digit_load = 1'b1;
          w_use_preset = 1'b1;
        end else if (start_stop && !w_zero) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear) begin
          w_digit_load = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (load) begin
          // load is ignored while running, and it still masks start_stop/tick
        end else if (start_stop) begin
          w_state_nxt = ST_PAUSE;
        end else if (tick && !w_zero) begin
          w_dec = 1'b1;
          if (w_one) begin
            w_state_nxt     = ST_EXPIRED;
            w_done_nxt      = 1'b1;
            w_alarm_cnt_nxt = '0;
          end
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          w_digit_load = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (load) begin
          w_digit_load = 1'b1;
          w_use_preset = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (start_stop) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        if (clear) begin
          w_digit_load = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (load) begin
          w_digit_load = 1'b1;
          w_use_preset = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (start_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (tick) begin
          w_alarm_cnt_nxt = w_alarm_cnt_inc;
          if ((ALARM_TICKS != 0) && (w_alarm_cnt_inc == AW'(ALARM_TICKS))) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_done      <= 1'b0;
      r_alarm_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_done      <= w_done_nxt;
      r_alarm_cnt <= w_alarm_cnt_nxt;
    end
  end

  assign running = (r_state == ST_RUN);
  assign alarm   = (r_state == ST_EXPIRED);
  assign done    = r_done;

  bcd_down_digit #(.MAX(DIGIT_MAX_ONES)) u_sec_ones (
    .clock      (clock),
    .reset      (reset),
    .load       (w_digit_load),
    .load_value (w_ld_so),
    .dec_en     (w_dec),
    .borrow_in  (1'b1),
    .digit      (sec_ones),
    .borrow_out (w_borrow_so)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX_TENS)) u_sec_tens (
    .clock      (clock),
    .reset      (reset),
    .load       (w_digit_load),
    .load_value (w_ld_st),
    .dec_en     (w_dec),
    .borrow_in  (w_borrow_so),
    .digit      (sec_tens),
    .borrow_out (w_borrow_st)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX_ONES)) u_min_ones (
    .clock      (clock),
    .reset      (reset),
    .load       (w_digit_load),
    .load_value (w_ld_mo),
    .dec_en     (w_dec),
    .borrow_in  (w_borrow_st),
    .digit      (min_ones),
    .borrow_out (w_borrow_mo)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX_TENS)) u_min_tens (
    .clock      (clock),
    .reset      (reset),
    .load       (w_digit_load),
    .load_value (w_ld_mt),
    .dec_en     (w_dec),
    .borrow_in  (w_borrow_mo),
    .digit      (min_tens),
    .borrow_out (w_borrow_mt)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus pushes expected output
// snapshots into a queue, a monitor on the falling edge pops and compares.
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick, load, start_stop, clear;
  logic [3:0] p_mt, p_mo, p_st, p_so;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done, alarm;

  always #5 clock = ~clock;

  countdown_timer #(.ALARM_TICKS(10)) dut (
    .clock           (clock),
    .reset           (reset),
    .tick            (tick),
    .load            (load),
    .start_stop      (start_stop),
    .clear           (clear),
    .preset_min_tens (p_mt),
    .preset_min_ones (p_mo),
    .preset_sec_tens (p_st),
    .preset_sec_ones (p_so),
    .min_tens        (min_tens),
    .min_ones        (min_ones),
    .sec_tens        (sec_tens),
    .sec_ones        (sec_ones),
    .running         (running),
    .done            (done),
    .alarm           (alarm)
  );

  typedef struct {
    string       name;
    logic [15:0] cnt;
    logic        run;
    logic        dn;
    logic        alm;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  // Seconds-based reference: convert a seconds total to MM:SS BCD.
  function automatic logic [15:0] bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic expect_out(input string name, input logic [15:0] cnt,
                            input logic run, input logic dn, input logic alm);
    exp_t e;
    e.name = name; e.cnt = cnt; e.run = run; e.dn = dn; e.alm = alm;
    q.push_back(e);
  endtask

  // Monitor: outputs only change on rising edges or async reset, so the
  // falling edge is a stable sample point.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      checks++;
      if ({min_tens, min_ones, sec_tens, sec_ones} !== m_e.cnt ||
          running !== m_e.run || done !== m_e.dn || alarm !== m_e.alm) begin
        errors++;
        $display("FAIL %s: got cnt=%h running=%b done=%b alarm=%b, expected cnt=%h running=%b done=%b alarm=%b",
                 m_e.name, {min_tens, min_ones, sec_tens, sec_ones}, running, done, alarm,
                 m_e.cnt, m_e.run, m_e.dn, m_e.alm);
      end
    end
  end

  task automatic step(input logic t, input logic ld, input logic ss, input logic clr);
    @(negedge clock);
    #1;
    tick = t; load = ld; start_stop = ss; clear = clr;
    @(posedge clock);
    #1;
    tick = 1'b0; load = 1'b0; start_stop = 1'b0; clear = 1'b0;
  endtask

  task automatic set_preset(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    p_mt = a; p_mo = b; p_st = c; p_so = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick = 1'b0; load = 1'b0; start_stop = 1'b0; clear = 1'b0;
    set_preset(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    expect_out("reset", 16'h0000, 0, 0, 0);

    // Borrow chain across minutes
    set_preset(4'd1, 4'd0, 4'd0, 4'd0);
    step(0, 1, 0, 0); expect_out("load_1000", 16'h1000, 0, 0, 0);
    step(0, 0, 1, 0); expect_out("start_1000", 16'h1000, 1, 0, 0);
    step(1, 0, 0, 0); expect_out("tick_0959", 16'h0959, 1, 0, 0);
    for (int i = 1; i <= 60; i++) begin
      step(1, 0, 0, 0);
      expect_out("chain_tick", bcd(599 - i), 1, 0, 0);
    end
    step(0, 0, 0, 1); expect_out("clear_run", 16'h0000, 0, 0, 0);

    // Expiry and alarm auto-silence
    set_preset(4'd0, 4'd0, 4'd0, 4'd2);
    step(0, 1, 0, 0); expect_out("load_0002", 16'h0002, 0, 0, 0);
    step(0, 0, 1, 0); expect_out("start_0002", 16'h0002, 1, 0, 0);
    step(1, 0, 0, 0); expect_out("tick_0001", 16'h0001, 1, 0, 0);
    step(1, 0, 0, 0); expect_out("expire", 16'h0000, 0, 1, 1);
    step(0, 0, 0, 0); expect_out("done_one_cycle", 16'h0000, 0, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      step(1, 0, 0, 0);
      expect_out("alarm_hold", 16'h0000, 0, 0, 1);
    end
    step(1, 0, 0, 0); expect_out("alarm_silence", 16'h0000, 0, 0, 0);
    step(0, 0, 1, 0); expect_out("idle_after_alarm", 16'h0000, 0, 0, 0);

    // Pause with coincident tick
    set_preset(4'd0, 4'd0, 4'd0, 4'd5);
    step(0, 1, 0, 0); expect_out("load_0005", 16'h0005, 0, 0, 0);
    step(0, 0, 1, 0); expect_out("start_0005", 16'h0005, 1, 0, 0);
    step(1, 0, 1, 0); expect_out("pause_tick", 16'h0005, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      expect_out("pause_hold", 16'h0005, 0, 0, 0);
    end
    step(0, 0, 1, 0); expect_out("resume", 16'h0005, 1, 0, 0);
    step(1, 0, 0, 0); expect_out("resume_tick", 16'h0004, 1, 0, 0);
    step(0, 0, 0, 1); expect_out("clear_0004", 16'h0000, 0, 0, 0);

    // Zero start and input priority
    step(0, 0, 1, 0); expect_out("zero_start", 16'h0000, 0, 0, 0);
    set_preset(4'd0, 4'd3, 4'd1, 4'd7);
    step(0, 1, 0, 0); expect_out("load_0317", 16'h0317, 0, 0, 0);
    step(0, 0, 1, 0); expect_out("start_0317", 16'h0317, 1, 0, 0);
    step(0, 1, 0, 0); expect_out("load_in_run", 16'h0317, 1, 0, 0);
    set_preset(4'd4, 4'd4, 4'd4, 4'd4);
    step(1, 1, 0, 1); expect_out("clr_ld_tick", 16'h0000, 0, 0, 0);
    step(0, 0, 1, 0); expect_out("zero_start2", 16'h0000, 0, 0, 0);

    // Preset clamping and full-range countdown
    set_preset(4'hF, 4'hF, 4'h7, 4'hC);
    step(0, 1, 0, 0); expect_out("clamp_load", 16'h5959, 0, 0, 0);
    step(0, 0, 1, 0); expect_out("start_5959", 16'h5959, 1, 0, 0);
    for (int i = 0; i < 3598; i++) step(1, 0, 0, 0);
    expect_out("full_0001", 16'h0001, 1, 0, 0);
    step(1, 0, 0, 0); expect_out("full_done", 16'h0000, 0, 1, 1);
    step(0, 0, 0, 1); expect_out("clear_expired", 16'h0000, 0, 0, 0);

    // Asynchronous reset mid-count
    set_preset(4'd1, 4'd2, 4'd3, 4'd4);
    step(0, 1, 0, 0); expect_out("load_1234", 16'h1234, 0, 0, 0);
    step(0, 0, 1, 0); expect_out("start_1234", 16'h1234, 1, 0, 0);
    @(posedge clock);
    #2 reset = 1'b1;
    expect_out("async_reset", 16'h0000, 0, 0, 0);
    @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    step(1, 0, 0, 0); expect_out("tick_after_reset", 16'h0000, 0, 0, 0);
    step(0, 0, 1, 0); expect_out("start_after_reset", 16'h0000, 0, 0, 0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

- Countdown timer for the clock display: counts an MM:SS value down to 00:00 in BCD, one step per 1 Hz tick.
- Raises a done pulse and a latched alarm at expiry.
- Complements the up-counting seconds/minutes chain. Digit outputs use the same 4-bit BCD format, so they feed the existing display path unchanged.
- Control inputs are single-cycle pulses from the debounced-button logic.

## Interface
Parameters:
- ALARM_TICKS, 10: number of ticks the alarm stays asserted before auto-silencing; 0 = never auto-silence.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; forces reset state immediately
- tick  in  1  one-cycle enable, 1 Hz, synchronous to clock
- load  in  1  one-cycle pulse: copy preset digits into count
- start_stop  in  1  one-cycle pulse: run/pause toggle
- clear  in  1  one-cycle pulse: count to 00:00, state IDLE
- preset_min_tens, preset_min_ones, preset_sec_tens, preset_sec_ones  in  4 each  BCD preset
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  current count, BCD
- running  out  1  high while state RUN
- done  out  1  one-cycle pulse on the edge the count reaches 00:00 from RUN
- alarm  out  1  high while state EXPIRED

## Operation
Range and preset clamping:
- Legal range is 00:00 to 59:59.
- At load, out-of-range preset digits clamp: ones digits >9 load 9, tens digits >5 load 5.

Decrement, applied on tick in RUN only:
- sec_ones 0→9 with borrow, else -1.
- sec_tens 0→5 with borrow on borrow-in.
- min_ones 0→9 with borrow on borrow-in.
- min_tens -1 on borrow-in.
- Example: 10:00 → 09:59; 00:10 → 00:09.

Input priority per cycle: clear > load > start_stop > tick. Lower-priority events in the same cycle are dropped.

States:
- IDLE: count held. load accepted. start_stop → RUN only if count ≠ 00:00, else ignored.
- RUN: tick decrements. Tick at 00:01 → count 00:00, done=1, next state EXPIRED. start_stop → PAUSE with no decrement that cycle. load ignored. clear → IDLE, count 00:00.
- PAUSE: count held. start_stop → RUN. load → new preset, IDLE. clear → IDLE, 00:00.
- EXPIRED: count 00:00, alarm=1.
  - start_stop or clear → IDLE.
  - load → new preset, IDLE.
  - Internal tick counter increments per tick. On reaching ALARM_TICKS (if ≠0) → IDLE.
  - Tick counter cleared on entry to EXPIRED.

## Timing
- All outputs registered. Event at edge N is reflected in outputs after edge N.
- Latency from input pulse to output change is 1 clock.
- done and the transition to EXPIRED occur on the same edge that writes 00:00. done is high for exactly one cycle.
- alarm rises with done. alarm falls on the edge that leaves EXPIRED.
- running follows the state register with no extra delay.
- Reset values: all digits 0, state IDLE, running 0, done 0, alarm 0, alarm tick counter 0.
- Reset asserted mid-count clears immediately, without waiting for a clock edge. The first clock edge after reset release behaves as from IDLE.
- The block never wraps below 00:00; RUN cannot be entered with count 00:00.

## Structure
- Shared package holds:
  - state encoding constants (IDLE, RUN, PAUSE, EXPIRED; 2 bits);
  - BCD limits DIGIT_MAX_ONES=9 and DIGIT_MAX_TENS=5;
  - the 4-bit BCD digit width.
- One sub-module, bcd_down_digit:
  - parameter MAX;
  - inputs: clock, reset, load, load_value, dec_en, borrow_in;
  - outputs: digit, borrow_out (asserted when digit=0 and borrow_in).
- Instantiate bcd_down_digit four times in a borrow chain.
- Top level holds:
  - FSM;
  - preset clamping;
  - zero/00:01 detect;
  - alarm tick counter, width $clog2(ALARM_TICKS+1), minimum 1.

## Test plan
- Borrow chain: load 10:00, start, 1 tick → 09:59; 60 more ticks → 08:59. done stays 0 throughout.
- Expiry: load 00:02, start, 2 ticks → 00:00; done high exactly 1 cycle; alarm=1, running=0. With ALARM_TICKS=10, 10 more ticks → alarm=0, state IDLE.
- Pause with coincident tick: load 00:05, start, pulse start_stop in the same cycle as a tick → count stays 00:05, running=0. Further ticks do not change the count. start_stop again → running=1.
- Priority and zero start: start_stop at 00:00 → stays IDLE. During RUN at 03:17, assert clear+load+tick in one cycle → 00:00, IDLE.
- Clamping: preset digits F,F,7,C → count loads 59:59. 3599 ticks after start → done.
- Async reset: assert reset between clock edges while RUN at 12:34 → outputs 0 immediately. Release reset → IDLE; a tick leaves the count at 00:00.
